// File: rtl/arm_regfile_32x64.sv
// 32 x 64-bit integer register file: two combinational read ports, one write port, X31 reads zero.
// Built structurally from a write decoder, enabled registers and bit-slice read muxes.
`timescale 1ns/1ps

module arm_regfile_dec5to32 (
  input  logic        en_i,
  input  logic [4:0]  addr_i,
  output logic [31:0] sel_o
);
  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o[addr_i] = 1'b1;
    end
  end
endmodule

module arm_regfile_reg64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [63:0] d_i,
  output logic [63:0] q_o
);
  logic [63:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

module arm_regfile_mux32to1 (
  input  logic [31:0] d_i,
  input  logic [4:0]  sel_i,
  output logic        y_o
);
  assign y_o = d_i[sel_i];
endmodule

module arm_regfile_32x64 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [4:0]  WriteRegister,
  input  logic [63:0] WriteData,
  input  logic        RegWrite,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2
);
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 64;

  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   reg_q   [NUM_REGS];
  logic [NUM_REGS-1:0] bit_col [DATA_W];

  // X31 has no storage, so its decoder output is intentionally left unconnected.
  logic unused_x31_sel;
  assign unused_x31_sel = wr_sel[NUM_REGS-1];

  arm_regfile_dec5to32 u_dec (
    .en_i   (RegWrite),
    .addr_i (WriteRegister),
    .sel_o  (wr_sel)
  );

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
    arm_regfile_reg64 u_reg (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (wr_sel[r]),
      .d_i   (WriteData),
      .q_o   (reg_q[r])
    );
  end

  assign reg_q[NUM_REGS-1] = '0;

  // Transpose storage into per-bit columns feeding one mux pair per bit position.
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
      assign bit_col[b][r] = reg_q[r][b];
    end

    arm_regfile_mux32to1 u_mux1 (
      .d_i   (bit_col[b]),
      .sel_i (ReadRegister1),
      .y_o   (ReadData1[b])
    );

    arm_regfile_mux32to1 u_mux2 (
      .d_i   (bit_col[b]),
      .sel_i (ReadRegister2),
      .y_o   (ReadData2[b])
    );
  end
endmodule

// File: tb/tb_arm_regfile_32x64.sv
// Directed bench for arm_regfile_32x64 with hand-computed expected values.
`timescale 1ns/1ps

module tb_arm_regfile_32x64;
  logic        clk;
  logic        reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int vectors;
  int miscompares;

  arm_regfile_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] base;
    base          = 64'hAAAA000000000000;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd5;
    WriteRegister = 5'd0;
    WriteData     = '0;

    // Reset state
    #1;
    check("reset_rd1_x0", ReadData1, 64'h0);
    check("reset_rd2_x5", ReadData2, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // X31 write attempt is discarded
    @(negedge clk);
    WriteRegister = 5'd31;
    WriteData     = 64'hDEADBEEFCAFEBABE;
    RegWrite      = 1'b1;
    @(negedge clk);
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    #1;
    check("x31_rd1", ReadData1, 64'h0);
    check("x31_rd2", ReadData2, 64'h0);
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd30;
    #1;
    check("x31_no_alias_x0", ReadData1, 64'h0);
    check("x31_no_alias_x30", ReadData2, 64'h0);

    // Full write then readback sweep
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      WriteRegister = 5'(i);
      WriteData     = base + 64'(i);
      RegWrite      = 1'b1;
      @(negedge clk);
      RegWrite      = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(i);
      #1;
      check("sweep_rd1", ReadData1, (i < 31) ? base + 64'(i) : 64'h0);
      check("sweep_rd2", ReadData2, (i < 31) ? base + 64'(i) : 64'h0);
    end

    // RegWrite=0 gating
    @(negedge clk);
    WriteRegister = 5'd5;
    WriteData     = 64'hFFFFFFFFFFFFFFFF;
    RegWrite      = 1'b0;
    repeat (3) @(negedge clk);
    ReadRegister1 = 5'd5;
    #1;
    check("gate_x5", ReadData1, 64'hAAAA000000000005);

    // Dual-port independence and mid-cycle address changes
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd30;
    #1;
    check("dual_rd1_x3", ReadData1, 64'hAAAA000000000003);
    check("dual_rd2_x30", ReadData2, 64'hAAAA00000000001E);
    #1;
    ReadRegister1 = 5'd30;
    ReadRegister2 = 5'd17;
    #1;
    check("swap_rd1_x30", ReadData1, 64'hAAAA00000000001E);
    check("swap_rd2_x17", ReadData2, 64'hAAAA000000000011);

    // Bit ordering with asymmetric pattern
    @(negedge clk);
    WriteRegister = 5'd12;
    WriteData     = 64'h8000000000000001;
    RegWrite      = 1'b1;
    @(negedge clk);
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd12;
    ReadRegister2 = 5'd12;
    #1;
    check("bitorder_rd1", ReadData1, 64'h8000000000000001);
    check("bitorder_rd2", ReadData2, 64'h8000000000000001);

    // Read-during-write: old value before edge, new after
    @(negedge clk);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    WriteRegister = 5'd7;
    WriteData     = 64'h0123456789ABCDEF;
    RegWrite      = 1'b1;
    #1;
    check("rdw_before", ReadData1, 64'hAAAA000000000007);
    @(posedge clk);
    #1;
    check("rdw_after_rd1", ReadData1, 64'h0123456789ABCDEF);
    check("rdw_after_rd2", ReadData2, 64'h0123456789ABCDEF);
    @(negedge clk);
    RegWrite = 1'b0;

    // Async reset between edges overrides writes
    #2;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd30;
    reset         = 1'b0;
    #1;
    check("areset_rd1_x7", ReadData1, 64'h0);
    check("areset_rd2_x30", ReadData2, 64'h0);
    WriteRegister = 5'd4;
    WriteData     = 64'h00000000DEAD0004;
    RegWrite      = 1'b1;
    ReadRegister1 = 5'd4;
    @(posedge clk);
    #1;
    check("areset_blocked_x4", ReadData1, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_write_x4", ReadData1, 64'h00000000DEAD0004);
    ReadRegister2 = 5'd7;
    #1;
    check("post_reset_x7_clear", ReadData2, 64'h0);
    @(negedge clk);
    RegWrite = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
